// File: rtl/ps2_kbd_pkg.sv
// Shared types and the PS/2 set-2 to Z88 key matrix map for the keyboard block.
// The map is indexed by {ext, code} and returns {hit, row, col}; bit index = row*8+col.
package ps2_kbd_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic       hit;
    logic [2:0] row;
    logic [2:0] col;
  } key_map_t;

  function automatic key_map_t km(input int unsigned r, input int unsigned c);
    km = '{hit: 1'b1, row: 3'(r), col: 3'(c)};
  endfunction

  // Anything not listed (including BAT 0xAA, ACK 0xFA, bare keypad codes) is a miss.
  function automatic key_map_t map_key(input logic ext, input logic [7:0] code);
    key_map_t m;
    m = '0;
    case ({ext, code})
      9'h03E: m = km(0, 0);  9'h03D: m = km(0, 1);  9'h031: m = km(0, 2);  9'h033: m = km(0, 3);
      9'h035: m = km(0, 4);  9'h036: m = km(0, 5);  9'h05A: m = km(0, 6);  9'h066: m = km(0, 7);
      9'h043: m = km(1, 0);  9'h03C: m = km(1, 1);  9'h032: m = km(1, 2);  9'h034: m = km(1, 3);
      9'h02C: m = km(1, 4);  9'h02E: m = km(1, 5);  9'h172: m = km(1, 6);  9'h055: m = km(1, 7);
      9'h044: m = km(2, 0);  9'h03B: m = km(2, 1);  9'h02A: m = km(2, 2);  9'h02B: m = km(2, 3);
      9'h02D: m = km(2, 4);  9'h025: m = km(2, 5);  9'h174: m = km(2, 6);  9'h04E: m = km(2, 7);
      9'h046: m = km(3, 0);  9'h042: m = km(3, 1);  9'h021: m = km(3, 2);  9'h023: m = km(3, 3);
      9'h024: m = km(3, 4);  9'h026: m = km(3, 5);  9'h175: m = km(3, 6);  9'h05B: m = km(3, 7);
      9'h04D: m = km(4, 0);  9'h03A: m = km(4, 1);  9'h022: m = km(4, 2);  9'h01B: m = km(4, 3);
      9'h01C: m = km(4, 4);  9'h01E: m = km(4, 5);  9'h16B: m = km(4, 6);  9'h054: m = km(4, 7);
      9'h045: m = km(5, 0);  9'h04B: m = km(5, 1);  9'h01A: m = km(5, 2);  9'h015: m = km(5, 3);
      9'h01D: m = km(5, 4);  9'h016: m = km(5, 5);  9'h029: m = km(5, 6);  9'h00D: m = km(5, 7);
      9'h052: m = km(6, 0);  9'h04C: m = km(6, 1);  9'h041: m = km(6, 2);  9'h011: m = km(6, 3);
      9'h014: m = km(6, 4);  9'h058: m = km(6, 5);  9'h012: m = km(6, 6);  9'h005: m = km(6, 7);
      9'h04A: m = km(7, 0);  9'h00E: m = km(7, 1);  9'h049: m = km(7, 2);  9'h114: m = km(7, 3);
      9'h006: m = km(7, 4);  9'h076: m = km(7, 5);  9'h111: m = km(7, 6);  9'h059: m = km(7, 7);
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: input synchronisers, glitch filters, 11-bit frame FSM.
// Optional partial-frame watchdog is built when PS2_WATCHDOG_EN is defined.
module ps2_rx
  import ps2_kbd_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2dat,
  output logic [7:0] rx_byte,
  output logic       byte_vld,
  output logic       frame_err,
  output logic       wd_timeout
);

  localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  // Index 0 carries ps2clk, index 1 carries ps2dat.
  logic [1:0]             sync1_q, sync1_d;
  logic [1:0]             sync2_q, sync2_d;
  logic [1:0]             flt_q, flt_d;
  logic [1:0][FCNT_W-1:0] fcnt_q, fcnt_d;
  logic                   flt_prev_q, flt_prev_d;
  logic                   fall;
  logic                   sample;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sync1_d    = {ps2dat, ps2clk};
    sync2_d    = sync1_q;
    flt_d      = flt_q;
    fcnt_d     = fcnt_q;
    flt_prev_d = flt_q[0];
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == flt_q[i]) begin
        fcnt_d[i] = '0;
      end else if (fcnt_q[i] == FCNT_W'(FILTER_LEN - 1)) begin
        flt_d[i]  = sync2_q[i];
        fcnt_d[i] = '0;
      end else begin
        fcnt_d[i] = fcnt_q[i] + 1'b1;
      end
    end
  end

  // Idle-high lines: reset the whole conditioning chain to 1 so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      flt_q      <= 2'b11;
      fcnt_q     <= '0;
      flt_prev_q <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      flt_q      <= flt_d;
      fcnt_q     <= fcnt_d;
      flt_prev_q <= flt_prev_d;
    end
  end

  assign fall   = flt_prev_q & ~flt_q[0];
  assign sample = flt_q[1];

  rx_state_e  state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       par_q;
  logic [7:0] byte_q;
  logic       byte_vld_q;
  logic       frame_err_q;
  logic       wd_hit;

`ifdef PS2_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_q, wd_d;

  assign wd_hit = (state_q != RX_IDLE) && (wd_q == WD_W'(TIMEOUT_CYC));

  always_comb begin
    wd_d = wd_q;
    if (state_q == RX_IDLE || fall) begin
      wd_d = '0;
    end else if (wd_q != WD_W'(TIMEOUT_CYC)) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC > 0);
  assign wd_hit         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RX_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      byte_q      <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (wd_hit) begin
        state_q     <= RX_IDLE;
        frame_err_q <= 1'b1;
      end else if (fall) begin
        unique case (state_q)
          RX_IDLE: begin
            if (!sample) begin
              state_q   <= RX_DATA;
              bit_cnt_q <= '0;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          RX_DATA: begin
            shift_q   <= {sample, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= RX_PARITY;
          end
          RX_PARITY: begin
            par_q   <= sample;
            state_q <= RX_STOP;
          end
          RX_STOP: begin
            // Odd parity: XOR over data and parity bit must be 1.
            if (sample && (^{shift_q, par_q})) begin
              byte_q     <= shift_q;
              byte_vld_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
            state_q <= RX_IDLE;
          end
          default: state_q <= RX_IDLE;
        endcase
      end
    end
  end

  assign rx_byte    = byte_q;
  assign byte_vld   = byte_vld_q;
  assign frame_err  = frame_err_q;
  assign wd_timeout = wd_hit;

endmodule

// File: rtl/ps2_kbd_matrix.sv
// PS/2 set-2 keyboard to Z88 64-bit key matrix (0 = pressed); decoder and matrix register.
// Define PS2_WATCHDOG_EN to build the partial-frame watchdog in the receiver.
module ps2_kbd_matrix
  import ps2_kbd_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2clk,
  input  logic        ps2dat,
  output logic [63:0] kbmatrix,
  output logic [7:0]  kbdval,
  output logic        key_stb,
  output logic        frame_err
);

  logic [7:0] rx_byte;
  logic       byte_vld;
  logic       wd_timeout;

  ps2_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2clk     (ps2clk),
    .ps2dat     (ps2dat),
    .rx_byte    (rx_byte),
    .byte_vld   (byte_vld),
    .frame_err  (frame_err),
    .wd_timeout (wd_timeout)
  );

  logic [63:0] kbmatrix_q, kbmatrix_d;
  logic [7:0]  kbdval_q, kbdval_d;
  logic        key_stb_q, key_stb_d;
  logic        ext_q, ext_d;
  logic        brk_q, brk_d;
  key_map_t    km_hit;
  logic [5:0]  idx;

  assign km_hit = map_key(ext_q, rx_byte);
  assign idx    = {km_hit.row, km_hit.col};

  always_comb begin
    kbmatrix_d = kbmatrix_q;
    kbdval_d   = kbdval_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    key_stb_d  = 1'b0;
    if (wd_timeout) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_vld) begin
      kbdval_d = rx_byte;
      if (rx_byte == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == PS2_BRK) begin
        brk_d = 1'b1;
      end else begin
        // Break writes 1 (released), make writes 0; strobe only on a real change.
        if (km_hit.hit) begin
          kbmatrix_d[idx] = brk_q;
          key_stb_d       = (kbmatrix_q[idx] != brk_q);
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kbmatrix_q <= '1;
      kbdval_q   <= '0;
      key_stb_q  <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      kbmatrix_q <= kbmatrix_d;
      kbdval_q   <= kbdval_d;
      key_stb_q  <= key_stb_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
    end
  end

  assign kbmatrix = kbmatrix_q;
  assign kbdval   = kbdval_q;
  assign key_stb  = key_stb_q;

endmodule

// File: tb/tb_ps2_kbd_matrix.sv
// Directed bench for ps2_kbd_matrix: bit-banged PS/2 frames with hand-computed matrix values.
module tb_ps2_kbd_matrix;

  localparam int HALF    = 20;
  localparam int TIMEOUT = 300;

  localparam logic [63:0] ALL1  = '1;
  localparam logic [63:0] A_DN  = ~(64'd1 << 36);
  localparam logic [63:0] UP_DN = ~(64'd1 << 30);
  localparam logic [63:0] SH_DN = ~((64'd1 << 54) | (64'd1 << 63));
  localparam logic [63:0] RS_DN = ~(64'd1 << 63);

  logic        clk;
  logic        reset;
  logic        ps2clk;
  logic        ps2dat;
  logic [63:0] kbmatrix;
  logic [7:0]  kbdval;
  logic        key_stb;
  logic        frame_err;

  int n_vec   = 0;
  int n_err   = 0;
  int stb_cnt = 0;
  int err_cnt = 0;

  ps2_kbd_matrix #(
    .FILTER_LEN  (8),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2clk    (ps2clk),
    .ps2dat    (ps2dat),
    .kbmatrix  (kbmatrix),
    .kbdval    (kbdval),
    .key_stb   (key_stb),
    .frame_err (frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (key_stb)   stb_cnt++;
    if (frame_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2dat = b;
    wait_clk(HALF);
    ps2clk = 1'b0;
    wait_clk(HALF);
    ps2clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(~bad_stop);
    ps2dat = 1'b1;
    wait_clk(40);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  initial begin
    ps2clk = 1'b1;
    ps2dat = 1'b1;
    reset  = 1'b1;
    wait_clk(5);
    check("rst_matrix", kbmatrix, ALL1);
    check("rst_kbdval", 64'(kbdval), 64'h00);
    check("rst_stb", 64'(key_stb), 64'd0);
    check("rst_err", 64'(frame_err), 64'd0);
    reset = 1'b0;
    wait_clk(5);

    send(8'h1C);
    check("a_make_matrix", kbmatrix, A_DN);
    check("a_make_stb", 64'(stb_cnt), 64'd1);
    check("a_make_kbdval", 64'(kbdval), 64'h1C);
    check("a_make_err", 64'(err_cnt), 64'd0);

    send(8'h1C);
    check("a_repeat_matrix", kbmatrix, A_DN);
    check("a_repeat_stb", 64'(stb_cnt), 64'd1);

    send(8'hF0); send(8'h1C);
    check("a_break_matrix", kbmatrix, ALL1);
    check("a_break_stb", 64'(stb_cnt), 64'd2);
    check("a_break_kbdval", 64'(kbdval), 64'h1C);

    send(8'hE0); send(8'h75);
    check("up_make_matrix", kbmatrix, UP_DN);
    check("up_make_stb", 64'(stb_cnt), 64'd3);
    check("up_make_kbdval", 64'(kbdval), 64'h75);

    send(8'h75);
    check("kp8_matrix", kbmatrix, UP_DN);
    check("kp8_stb", 64'(stb_cnt), 64'd3);

    send(8'hE0); send(8'hF0); send(8'h75);
    check("up_break_matrix", kbmatrix, ALL1);
    check("up_break_stb", 64'(stb_cnt), 64'd4);

    send(8'h12); send(8'h59);
    check("shifts_matrix", kbmatrix, SH_DN);
    check("shifts_stb", 64'(stb_cnt), 64'd6);
    send(8'hF0); send(8'h12);
    check("lsh_break_matrix", kbmatrix, RS_DN);
    send(8'hF0); send(8'h59);
    check("rsh_break_matrix", kbmatrix, ALL1);
    check("shifts_break_stb", 64'(stb_cnt), 64'd8);

    send(8'hAA); send(8'hFA);
    check("bat_ack_matrix", kbmatrix, ALL1);
    check("bat_ack_stb", 64'(stb_cnt), 64'd8);
    check("bat_ack_kbdval", 64'(kbdval), 64'hFA);

    send_frame(8'h1C, 1'b1, 1'b0);
    check("bad_par_err", 64'(err_cnt), 64'd1);
    check("bad_par_matrix", kbmatrix, ALL1);
    check("bad_par_kbdval", 64'(kbdval), 64'hFA);

    send_frame(8'h1C, 1'b0, 1'b1);
    check("bad_stop_err", 64'(err_cnt), 64'd2);
    check("bad_stop_kbdval", 64'(kbdval), 64'hFA);

    ps2clk = 1'b0;
    wait_clk(3);
    ps2clk = 1'b1;
    wait_clk(30);
    check("glitch_err", 64'(err_cnt), 64'd2);
    send(8'h1C);
    check("post_glitch_matrix", kbmatrix, A_DN);
    check("post_glitch_stb", 64'(stb_cnt), 64'd9);
    check("post_glitch_kbdval", 64'(kbdval), 64'h1C);

    send(8'hE0); send(8'hAA); send(8'h75);
    check("ext_clr_matrix", kbmatrix, A_DN);
    check("ext_clr_stb", 64'(stb_cnt), 64'd9);
    send(8'hF0); send(8'hAA); send(8'h1C);
    check("brk_clr_matrix", kbmatrix, A_DN);
    check("brk_clr_stb", 64'(stb_cnt), 64'd9);

    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    reset = 1'b1;
    wait_clk(3);
    reset  = 1'b0;
    ps2dat = 1'b1;
    wait_clk(40);
    check("midrst_matrix", kbmatrix, ALL1);
    check("midrst_kbdval", 64'(kbdval), 64'h00);
    check("midrst_err", 64'(err_cnt), 64'd2);
    check("midrst_stb", 64'(stb_cnt), 64'd9);

`ifdef PS2_WATCHDOG_EN
    send(8'hE0);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    ps2dat = 1'b1;
    wait_clk(TIMEOUT + 50);
    check("wd_err", 64'(err_cnt), 64'd3);
    send(8'h1C);
    check("wd_next_matrix", kbmatrix, A_DN);
    check("wd_next_stb", 64'(stb_cnt), 64'd10);
`else
    send(8'h1C);
    check("final_matrix", kbmatrix, A_DN);
    check("final_stb", 64'(stb_cnt), 64'd10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
